// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit
//
// Carries the fetch-stage branch prediction (taken bit + predicted target)
// through the Decode and Execute pipeline registers. In Execute it resolves
// the prediction against the actual outcome. It then produces the predictor
// training signals, a mispredict flag with its recovery PC, and saturating
// branch / mispredict performance counters.
//
// Ports:
//   clk_i               clock, rising-edge
//   reset_i             synchronous active-low reset
//   valid_fi_i          real instruction in Fetch
//   pc_src_pred_fi_i    predicted taken (from predictor)
//   pred_pc_target_fi_i predicted target (from predictor)
//   stall_de_i/flush_de_i  Decode register hold / bubble
//   stall_ex_i/flush_ex_i  Execute register hold / bubble
//   branch_op_ex_i      00 none, 01 cond branch, 10 jal, 11 jalr
//   branch_cond_ex_i    conditional branch evaluated taken
//   pc_target_ex_i      actual target computed in Execute
//   pc_plus4_ex_i       fall-through PC of the Execute instruction
//   pc_src_res_ex_o     resolved taken
//   target_match_ex_o   predicted target == actual target
//   mispredict_ex_o     fetch must redirect
//   recovery_pc_ex_o    redirect address
//   branch_cnt_o        retired branch/jump count (saturating)
//   mispredict_cnt_o    misprediction count (saturating)

module branch_resolution_unit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_fi_i,
    input  logic             pc_src_pred_fi_i,
    input  logic [31:0]      pred_pc_target_fi_i,
    input  logic             stall_de_i,
    input  logic             flush_de_i,
    input  logic             stall_ex_i,
    input  logic             flush_ex_i,
    input  logic [1:0]       branch_op_ex_i,
    input  logic             branch_cond_ex_i,
    input  logic [31:0]      pc_target_ex_i,
    input  logic [31:0]      pc_plus4_ex_i,
    output logic             pc_src_res_ex_o,
    output logic             target_match_ex_o,
    output logic             mispredict_ex_o,
    output logic [31:0]      recovery_pc_ex_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispredict_cnt_o
);

    logic             r_valid_de;
    logic             r_pred_taken_de;
    logic [31:0]      r_pred_target_de;
    logic             r_valid_ex;
    logic             r_pred_taken_ex;
    logic [31:0]      r_pred_target_ex;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic             w_res;
    logic             w_match;
    logic             w_mispredict;
    logic [31:0]      w_recovery_pc;
    logic             w_count_en;
    logic             w_is_branch;

    // Decode register: flush bubbles the entry (target left as-is), and
    // takes priority over stall.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_valid_de       <= 1'b0;
            r_pred_taken_de  <= 1'b0;
            r_pred_target_de <= '0;
        end else if (flush_de_i) begin
            r_valid_de       <= 1'b0;
            r_pred_taken_de  <= 1'b0;
        end else if (!stall_de_i) begin
            r_valid_de       <= valid_fi_i;
            r_pred_taken_de  <= pc_src_pred_fi_i;
            r_pred_target_de <= pred_pc_target_fi_i;
        end
    end

    // Execute register: same rules, fed from Decode.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_valid_ex       <= 1'b0;
            r_pred_taken_ex  <= 1'b0;
            r_pred_target_ex <= '0;
        end else if (flush_ex_i) begin
            r_valid_ex       <= 1'b0;
            r_pred_taken_ex  <= 1'b0;
        end else if (!stall_ex_i) begin
            r_valid_ex       <= r_valid_de;
            r_pred_taken_ex  <= r_pred_taken_de;
            r_pred_target_ex <= r_pred_target_de;
        end
    end

    // Resolution. An op of 00 predicted taken (predictor alias) falls out of
    // the direction compare as a mispredict with recovery to pc+4.
    always_comb begin
        w_is_branch   = (branch_op_ex_i != 2'b00);
        w_res         = ((branch_op_ex_i == 2'b01) && branch_cond_ex_i) ||
                        (branch_op_ex_i == 2'b10) || (branch_op_ex_i == 2'b11);
        w_match       = (r_pred_target_ex == pc_target_ex_i);
        w_mispredict  = r_valid_ex &&
                        ((r_pred_taken_ex != w_res) ||
                         (r_pred_taken_ex && w_res && !w_match));
        w_recovery_pc = w_res ? pc_target_ex_i : pc_plus4_ex_i;
        // Counting only when Execute advances keeps a stalled instruction
        // from being counted more than once.
        w_count_en    = r_valid_ex && !stall_ex_i;
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_count_en) begin
            if (w_is_branch && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_mispredict && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign pc_src_res_ex_o   = w_res;
    assign target_match_ex_o = w_match;
    assign mispredict_ex_o   = w_mispredict;
    assign recovery_pc_ex_o  = w_recovery_pc;
    assign branch_cnt_o      = r_branch_cnt;
    assign mispredict_cnt_o  = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolution_unit.sv
module tb_branch_resolution_unit;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_fi_i;
    logic        pc_src_pred_fi_i;
    logic [31:0] pred_pc_target_fi_i;
    logic        stall_de_i, flush_de_i, stall_ex_i, flush_ex_i;
    logic [1:0]  branch_op_ex_i;
    logic        branch_cond_ex_i;
    logic [31:0] pc_target_ex_i, pc_plus4_ex_i;

    logic        res32, match32, mis32;
    logic [31:0] rec32, bcnt32, mcnt32;
    logic        res4, match4, mis4;
    logic [31:0] rec4;
    logic [3:0]  bcnt4, mcnt4;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk_i = ~clk_i;

    branch_resolution_unit dut32 (
        .clk_i(clk_i), .reset_i(reset_i),
        .valid_fi_i(valid_fi_i), .pc_src_pred_fi_i(pc_src_pred_fi_i),
        .pred_pc_target_fi_i(pred_pc_target_fi_i),
        .stall_de_i(stall_de_i), .flush_de_i(flush_de_i),
        .stall_ex_i(stall_ex_i), .flush_ex_i(flush_ex_i),
        .branch_op_ex_i(branch_op_ex_i), .branch_cond_ex_i(branch_cond_ex_i),
        .pc_target_ex_i(pc_target_ex_i), .pc_plus4_ex_i(pc_plus4_ex_i),
        .pc_src_res_ex_o(res32), .target_match_ex_o(match32),
        .mispredict_ex_o(mis32), .recovery_pc_ex_o(rec32),
        .branch_cnt_o(bcnt32), .mispredict_cnt_o(mcnt32)
    );

    branch_resolution_unit #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i),
        .valid_fi_i(valid_fi_i), .pc_src_pred_fi_i(pc_src_pred_fi_i),
        .pred_pc_target_fi_i(pred_pc_target_fi_i),
        .stall_de_i(stall_de_i), .flush_de_i(flush_de_i),
        .stall_ex_i(stall_ex_i), .flush_ex_i(flush_ex_i),
        .branch_op_ex_i(branch_op_ex_i), .branch_cond_ex_i(branch_cond_ex_i),
        .pc_target_ex_i(pc_target_ex_i), .pc_plus4_ex_i(pc_plus4_ex_i),
        .pc_src_res_ex_o(res4), .target_match_ex_o(match4),
        .mispredict_ex_o(mis4), .recovery_pc_ex_o(rec4),
        .branch_cnt_o(bcnt4), .mispredict_cnt_o(mcnt4)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        bit          t;
        logic [31:0] tgt;
    } slot_t;

    slot_t m_de = '{0, 0, 32'h0};
    slot_t m_ex = '{0, 0, 32'h0};
    longint unsigned m_branches = 0;
    longint unsigned m_mispreds = 0;

    function automatic bit taken_of(logic [1:0] op, logic cond);
        case (op)
            2'd0:    return 1'b0;
            2'd1:    return cond;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit mispred_of(slot_t s, logic [1:0] op, logic cond, logic [31:0] actual);
        bit tk;
        tk = taken_of(op, cond);
        if (!s.v) return 1'b0;
        if (s.t != tk) return 1'b1;
        return tk && (s.tgt != actual);
    endfunction

    function automatic longint unsigned sat(longint unsigned v, int unsigned w);
        longint unsigned mx;
        mx = (64'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk_i) begin
        slot_t nde, nex;
        if (!reset_i) begin
            m_de = '{0, 0, 32'h0};
            m_ex = '{0, 0, 32'h0};
            m_branches = 0;
            m_mispreds = 0;
        end else begin
            if (m_ex.v && !stall_ex_i) begin
                if (branch_op_ex_i != 2'd0) m_branches++;
                if (mispred_of(m_ex, branch_op_ex_i, branch_cond_ex_i, pc_target_ex_i)) m_mispreds++;
            end
            nex = flush_ex_i ? '{0, 0, m_ex.tgt} : (stall_ex_i ? m_ex : m_de);
            nde = flush_de_i ? '{0, 0, m_de.tgt} :
                  (stall_de_i ? m_de : '{valid_fi_i, pc_src_pred_fi_i, pred_pc_target_fi_i});
            m_ex = nex;
            m_de = nde;
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            bit          e_res, e_mis, e_match;
            logic [31:0] e_rec;
            e_res   = taken_of(branch_op_ex_i, branch_cond_ex_i);
            e_match = (m_ex.tgt == pc_target_ex_i);
            e_mis   = mispred_of(m_ex, branch_op_ex_i, branch_cond_ex_i, pc_target_ex_i);
            e_rec   = e_res ? pc_target_ex_i : pc_plus4_ex_i;
            chk("res32", res32, e_res);
            chk("match32", match32, e_match);
            chk("mis32", mis32, e_mis);
            chk("rec32", rec32, e_rec);
            chk("bcnt32", bcnt32, sat(m_branches, 32));
            chk("mcnt32", mcnt32, sat(m_mispreds, 32));
            chk("res4", res4, e_res);
            chk("mis4", mis4, e_mis);
            chk("rec4", rec4, e_rec);
            chk("bcnt4", bcnt4, sat(m_branches, 4));
            chk("mcnt4", mcnt4, sat(m_mispreds, 4));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        valid_fi_i = 0; pc_src_pred_fi_i = 0; pred_pc_target_fi_i = '0;
        stall_de_i = 0; flush_de_i = 0; stall_ex_i = 0; flush_ex_i = 0;
        branch_op_ex_i = 2'd0; branch_cond_ex_i = 0;
        pc_target_ex_i = '0; pc_plus4_ex_i = '0;
    endtask

    task automatic rand_inputs();
        logic [31:0] pool [4];
        pool = '{32'h100, 32'h104, 32'h200, 32'h204};
        valid_fi_i          = $urandom_range(0, 3) != 0;
        pc_src_pred_fi_i    = $urandom_range(0, 1);
        pred_pc_target_fi_i = pool[$urandom_range(0, 3)];
        stall_de_i          = $urandom_range(0, 4) == 0;
        flush_de_i          = $urandom_range(0, 6) == 0;
        stall_ex_i          = $urandom_range(0, 4) == 0;
        flush_ex_i          = $urandom_range(0, 6) == 0;
        branch_op_ex_i      = 2'($urandom_range(0, 3));
        branch_cond_ex_i    = $urandom_range(0, 1);
        pc_target_ex_i      = pool[$urandom_range(0, 3)];
        pc_plus4_ex_i       = $urandom;
    endtask

    // Present a prediction in F, then advance two edges so it sits in EX.
    task automatic send(bit pred, logic [31:0] tgt);
        valid_fi_i = 1; pc_src_pred_fi_i = pred; pred_pc_target_fi_i = tgt;
        tick();
        valid_fi_i = 0; pc_src_pred_fi_i = 0; pred_pc_target_fi_i = '0;
        tick();
    endtask

    task automatic set_ex(logic [1:0] op, bit cond, logic [31:0] tgt, logic [31:0] p4);
        branch_op_ex_i = op; branch_cond_ex_i = cond;
        pc_target_ex_i = tgt; pc_plus4_ex_i = p4;
    endtask

    initial begin
        idle_inputs();
        // Reset with random inputs
        reset_i = 0;
        rand_inputs();
        tick();
        chk_en = 1;
        rand_inputs();
        tick();
        #2;
        chk("rst_mis", mis32, 0);
        chk("rst_bcnt", bcnt32, 0);
        chk("rst_mcnt", mcnt32, 0);
        chk("rst_bcnt4", bcnt4, 0);
        idle_inputs();
        reset_i = 1;
        tick();

        // Correct taken prediction
        send(1, 32'h100);
        set_ex(2'd1, 1, 32'h100, 32'h104);
        #2;
        chk("ok_res", res32, 1);
        chk("ok_match", match32, 1);
        chk("ok_mis", mis32, 0);
        tick();
        idle_inputs();
        chk("ok_bcnt", bcnt32, 1);

        // Direction mispredict
        send(0, 32'h0);
        set_ex(2'd1, 1, 32'h200, 32'h84);
        #2;
        chk("dir_mis", mis32, 1);
        chk("dir_rec", rec32, 32'h200);
        tick();
        idle_inputs();
        chk("dir_mcnt", mcnt32, 1);

        // Wrong jalr target
        send(1, 32'h300);
        set_ex(2'd3, 0, 32'h340, 32'h90);
        #2;
        chk("jalr_mis", mis32, 1);
        chk("jalr_rec", rec32, 32'h340);
        tick();
        idle_inputs();

        // Predictor alias on a non-branch
        send(1, 32'h500);
        set_ex(2'd0, 0, 32'h999, 32'h88);
        #2;
        chk("alias_res", res32, 0);
        chk("alias_mis", mis32, 1);
        chk("alias_rec", rec32, 32'h88);
        tick();
        idle_inputs();
        chk("alias_bcnt", bcnt32, 3);
        chk("alias_mcnt", mcnt32, 3);

        // Stall in EX for 3 cycles: stable outputs, single count
        send(1, 32'h600);
        set_ex(2'd1, 1, 32'h600, 32'h604);
        stall_ex_i = 1;
        repeat (3) begin
            #2;
            chk("stall_res", res32, 1);
            chk("stall_mis", mis32, 0);
            tick();
            chk("stall_bcnt", bcnt32, 3);
        end
        stall_ex_i = 0;
        tick();
        idle_inputs();
        chk("stall_rel_bcnt", bcnt32, 4);

        // Flush + stall on Decode blocks a pred=1 entry
        valid_fi_i = 1; pc_src_pred_fi_i = 1; pred_pc_target_fi_i = 32'h700;
        flush_de_i = 1; stall_de_i = 1;
        tick();
        idle_inputs();
        tick();
        set_ex(2'd0, 0, 32'h700, 32'h704);
        #2;
        chk("flush_mis_nop", mis32, 0);
        set_ex(2'd1, 1, 32'h123, 32'h704);
        #1;
        chk("flush_mis_br", mis32, 0);
        tick();
        idle_inputs();
        chk("flush_bcnt", bcnt32, 4);

        // Saturation: 20 back-to-back mispredicting branches
        valid_fi_i = 1; pc_src_pred_fi_i = 0; pred_pc_target_fi_i = '0;
        set_ex(2'd1, 1, 32'h800, 32'h804);
        repeat (22) tick();
        idle_inputs();
        chk("sat_bcnt4", bcnt4, 4'd15);
        chk("sat_mcnt4", mcnt4, 4'd15);
        chk("sat_bcnt32", bcnt32, 24);
        chk("sat_mcnt32", mcnt32, 23);
        tick();

        // Randomized traffic with occasional reset
        repeat (3000) begin
            rand_inputs();
            reset_i = $urandom_range(0, 127) != 0;
            tick();
        end
        reset_i = 1;
        idle_inputs();
        tick();
        @(negedge clk_i);
        #1;
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
